seq_comparator: RTL

Multi-cycle, handshaked magnitude/equality comparator for the MIPS datapath. It accepts two WIDTH-bit operands, an operation code and a signedness flag, and scans the operands SLICE bits at a time, most-significant slice first. It returns one decision bit plus raw eq/lt flags. It replaces single-cycle wide comparators where timing closure is critical and serves branch/set-on-less-than units that tolerate variable latency.

---
 rtl/seq_comparator_if.sv | 8 +
 rtl/seq_comparator.sv | 92 +++++++++
 2 files changed

// File: rtl/seq_comparator_if.sv
// seq_comparator_if: comparator handshake bundle; master drives in_valid/a/b/op/sgn/out_ready, slave drives in_ready/out_valid/result/eq/lt
interface seq_comparator_if #(parameter int WIDTH = 32);
  logic in_valid, in_ready, sgn, out_valid, out_ready, result, eq, lt;
  logic [WIDTH-1:0] a, b;
  logic [2:0] op;
  modport master(output in_valid, a, b, op, sgn, out_ready, input in_ready, out_valid, result, eq, lt);
  modport slave(input in_valid, a, b, op, sgn, out_ready, output in_ready, out_valid, result, eq, lt);
endinterface

// File: rtl/seq_comparator.sv
// seq_comparator: sliced MSB-first magnitude/equality compare (ports clk, rst_n, s: seq_comparator_if.slave); SEQ_CMP_EARLY_EXIT_EN ends SCAN on the first differing slice
module seq_comparator #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input logic clk,
  input logic rst_n,
  seq_comparator_if.slave s
);
  localparam int N = WIDTH / SLICE;
  localparam int KW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0] op_q, op_d;
  logic [KW-1:0] k_q, k_d;
  logic sgn_q, sgn_d, dec_q, dec_d, eq_q, eq_d, lt_q, lt_d;
  logic [SLICE-1:0] sa, sb, flip;
  logic top, hit, last;
  always_comb begin
    top = k_q == KW'(N - 1);
    flip = SLICE'(sgn_q & top) << (SLICE - 1);
    sa = SLICE'(a_q >> (32'(k_q) * SLICE)) ^ flip;
    sb = SLICE'(b_q >> (32'(k_q) * SLICE)) ^ flip;
    hit = !dec_q && sa != sb;
    last = k_q == '0;
`ifdef SEQ_CMP_EARLY_EXIT_EN
    last = last || hit;
`endif
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    sgn_d = sgn_q;
    k_d = k_q;
    dec_d = dec_q;
    eq_d = eq_q;
    lt_d = lt_q;
    if (state_q == IDLE && s.in_valid) begin
      state_d = SCAN;
      a_d = s.a;
      b_d = s.b;
      op_d = s.op;
      sgn_d = s.sgn;
      k_d = KW'(N - 1);
      dec_d = 1'b0;
      eq_d = 1'b0;
      lt_d = 1'b0;
    end else if (state_q == SCAN) begin
      k_d = k_q - KW'(1);
      dec_d = dec_q | hit;
      eq_d = hit ? 1'b0 : (!dec_q && k_q == '0) ? 1'b1 : eq_q;
      lt_d = hit ? sa < sb : (!dec_q && k_q == '0) ? 1'b0 : lt_q;
      state_d = last ? DONE : SCAN;
    end else if (state_q == DONE && s.out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      sgn_q <= 1'b0;
      k_q <= '0;
      dec_q <= 1'b0;
      eq_q <= 1'b0;
      lt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      sgn_q <= sgn_d;
      k_q <= k_d;
      dec_q <= dec_d;
      eq_q <= eq_d;
      lt_q <= lt_d;
    end
  end
  assign s.in_ready = state_q == IDLE;
  assign s.out_valid = state_q == DONE;
  assign s.eq = eq_q;
  assign s.lt = lt_q;
  assign s.result = s.out_valid & (op_q == 3'd0 ? eq_q :
                                   op_q == 3'd1 ? !eq_q :
                                   op_q == 3'd2 ? lt_q :
                                   op_q == 3'd3 ? lt_q | eq_q :
                                   op_q == 3'd4 ? !(lt_q | eq_q) :
                                   op_q == 3'd5 ? !lt_q : 1'b0);
endmodule
